// File: rtl/mem_access_stage.sv
// Memory stage: executes loads/stores over a ready-handshake data bus and
// presents a registered write-back result, stalling upstream while busy.
module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid_in,
    input  logic [31:0] alu_data,
    input  logic [31:0] memory_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic        reg_write,
    input  logic [4:0]  rd,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    output logic        valid_out,
    output logic [31:0] wb_data,
    output logic [4:0]  rd_out,
    output logic        reg_write_out,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        state_dbg
);

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    localparam int            CW   = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_count;
    logic [2:0]    r_funct3;
    logic [1:0]    r_addr_lo;
    logic          r_is_load;
    logic [4:0]    r_rd;
    logic          r_reg_write;

    logic          w_is_mem;
    logic          w_illegal;
    logic          w_misaligned;
    logic          w_start;
    logic          w_timeout_hit;
    logic          w_done;
    logic [3:0]    w_st_be;
    logic [31:0]   w_st_wdata;
    logic [31:0]   w_rsh_b;
    logic [31:0]   w_rsh_h;
    logic [31:0]   w_load_val;

    // Request decode, evaluated only while idle.
    assign w_is_mem     = mem_read | mem_write;
    assign w_illegal    = (mem_read & mem_write)
                        | (mem_read & ((funct3 == 3'b011) | (funct3[2:1] == 2'b11)))
                        | (mem_write & (funct3[2] | (funct3 == 3'b011)));
    assign w_misaligned = ((funct3[1:0] == 2'b01) & alu_data[0])
                        | ((funct3[1:0] == 2'b10) & (alu_data[1:0] != 2'b00));
    assign w_start      = (r_state == S_IDLE) & valid_in & w_is_mem & ~w_illegal & ~w_misaligned;

    assign w_timeout_hit = (r_state == S_BUSY) & ~bus_ready & (r_count == LAST);
    assign w_done        = (r_state == S_BUSY) & (bus_ready | w_timeout_hit);
    assign state_dbg     = r_state;

    always_comb begin
        w_st_be    = 4'b1111;
        w_st_wdata = memory_data;
        case (funct3[1:0])
            2'b00: begin
                w_st_be    = 4'b0001 << alu_data[1:0];
                w_st_wdata = {4{memory_data[7:0]}};
            end
            2'b01: begin
                w_st_be    = alu_data[1] ? 4'b1100 : 4'b0011;
                w_st_wdata = {2{memory_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_rsh_b = bus_rdata >> {r_addr_lo, 3'b000};
    assign w_rsh_h = bus_rdata >> {r_addr_lo[1], 4'b0000};

    always_comb begin
        w_load_val = bus_rdata;
        case (r_funct3)
            3'b000:  w_load_val = {{24{w_rsh_b[7]}}, w_rsh_b[7:0]};
            3'b100:  w_load_val = {24'd0, w_rsh_b[7:0]};
            3'b001:  w_load_val = {{16{w_rsh_h[15]}}, w_rsh_h[15:0]};
            3'b101:  w_load_val = {16'd0, w_rsh_h[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next_state = S_BUSY;
            S_BUSY:  if (w_done)  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Held low during reset so a frozen upstream instruction cannot stall.
    always_comb begin
        stall = 1'b0;
        case (r_state)
            S_IDLE:  stall = w_start;
            S_BUSY:  stall = ~bus_ready & ~w_timeout_hit;
            default: stall = 1'b0;
        endcase
        stall = stall & reset_n;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= 32'd0;
            bus_wdata   <= 32'd0;
            bus_be      <= 4'd0;
            r_count     <= '0;
            r_funct3    <= 3'd0;
            r_addr_lo   <= 2'd0;
            r_is_load   <= 1'b0;
            r_rd        <= 5'd0;
            r_reg_write <= 1'b0;
        end else begin
            if (w_start) begin
                bus_req     <= 1'b1;
                bus_we      <= mem_write;
                bus_addr    <= {alu_data[31:2], 2'b00};
                bus_be      <= mem_write ? w_st_be : 4'd0;
                bus_wdata   <= mem_write ? w_st_wdata : 32'd0;
                r_count     <= '0;
                r_funct3    <= funct3;
                r_addr_lo   <= alu_data[1:0];
                r_is_load   <= mem_read;
                r_rd        <= rd;
                r_reg_write <= reg_write;
            end else if (w_done) begin
                bus_req <= 1'b0;
            end else if (r_state == S_BUSY) begin
                r_count <= r_count + CW'(1);
            end
        end
    end

    // Result register: pulses clear every cycle, payload holds until next result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_out     <= 1'b0;
            fault         <= 1'b0;
            fault_cause   <= 2'b00;
            wb_data       <= 32'd0;
            rd_out        <= 5'd0;
            reg_write_out <= 1'b0;
        end else begin
            valid_out   <= 1'b0;
            fault       <= 1'b0;
            fault_cause <= 2'b00;
            if ((r_state == S_IDLE) && valid_in && !w_is_mem) begin
                valid_out     <= 1'b1;
                wb_data       <= alu_data;
                rd_out        <= rd;
                reg_write_out <= reg_write;
            end else if ((r_state == S_IDLE) && valid_in && (w_illegal || w_misaligned)) begin
                valid_out     <= 1'b1;
                fault         <= 1'b1;
                fault_cause   <= w_illegal ? 2'b11 : 2'b01;
                wb_data       <= 32'd0;
                rd_out        <= rd;
                reg_write_out <= 1'b0;
            end else if (w_done) begin
                valid_out <= 1'b1;
                rd_out    <= r_rd;
                if (w_timeout_hit) begin
                    fault         <= 1'b1;
                    fault_cause   <= 2'b10;
                    wb_data       <= 32'd0;
                    reg_write_out <= 1'b0;
                end else if (r_is_load) begin
                    wb_data       <= w_load_val;
                    reg_write_out <= r_reg_write;
                end else begin
                    wb_data       <= 32'd0;
                    reg_write_out <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the RISC-V pipeline. Consumes the execute-stage results: ALU result used as address, store data, and memory-control bits.
- Performs loads and stores over a ready-handshake data-memory bus, then presents a registered write-back result.
- Stalls the upstream pipeline while a bus access is outstanding.
- Its wb_data output drives the execute stage's mem_forward_data path.

Parameters:
- TIMEOUT, 16, max BUSY cycles without bus_ready before abort.

Ports:
- clk  input  1  clock
- reset_n  input  1  async active-low reset
- valid_in  input  1  instruction present at stage input
- alu_data  input  32  ALU result / effective address
- memory_data  input  32  rs2 store data
- mem_read  input  1  load
- mem_write  input  1  store
- funct3  input  3  access size/sign
- reg_write  input  1  instruction writes rd
- rd  input  5  destination register
- stall  output  1  hold upstream this cycle (combinational)
- bus_req  output  1  bus request (registered)
- bus_we  output  1  write strobe
- bus_addr  output  32  word-aligned address ({addr[31:2],2'b00})
- bus_wdata  output  32  lane-replicated store data
- bus_be  output  4  byte enables
- bus_ready  input  1  bus completes access this cycle
- bus_rdata  input  32  read word, valid when bus_ready
- valid_out  output  1  result valid (one cycle per instruction)
- wb_data  output  32  write-back value
- rd_out  output  5  destination register
- reg_write_out  output  1  write-back enable
- fault  output  1  fault pulse, coincident with valid_out
- fault_cause  output  2  01 misaligned, 10 timeout, 11 illegal

Behaviour:
- The clock is clk. Reset is asynchronous and active-low (reset_n). Reset forces the FSM to IDLE and clears every output, register and counter to 0. Reset mid-BUSY drops bus_req immediately and abandons the access.
- FSM states: IDLE, BUSY.
- Pass-through (valid_in & ~mem_read & ~mem_write):
  - Latency 1.
  - At the next cycle: valid_out=1, wb_data=alu_data, rd_out=rd, reg_write_out=reg_write.
  - No stall.
- Fault checks happen in IDLE before any bus access:
  - Illegal (cause 11) when both mem_read and mem_write are set, when funct3 is in {011,110,111} for a load, or when funct3 is in {011..111} for a store.
  - Misaligned (cause 01) when a halfword has addr[0]=1, or a word has addr[1:0]!=0.
  - A fault gives a 1-cycle result with no bus activity: valid_out=1, fault=1, reg_write_out=0, wb_data=0, and no stall.
- Start: in IDLE with valid_in, a legal memory op and an aligned address:
  - stall=1 in that cycle.
  - The request is captured; next cycle state=BUSY and bus_req=1.
  - bus_addr, bus_we, bus_be and bus_wdata stay stable while BUSY.
- In BUSY:
  - stall = ~bus_ready & ~timeout_hit.
  - On bus_ready: bus_req=0 and state=IDLE at the next edge, with valid_out=1 at the next cycle.
  - The upstream instruction advances on that same edge.
- Minimum memory-op latency is 2 cycles (start, 1 BUSY cycle with ready).
- Load data uses byte b = rdata >> (8*addr[1:0]) and halfword h = rdata >> (16*addr[1]):
  - LB (000) sign-extends b; LBU (100) zero-extends b.
  - LH (001) sign-extends h; LHU (101) zero-extends h.
  - LW (010) takes the whole word.
  - reg_write_out = reg_write.
- Stores:
  - SB: bus_be = 4'b0001 << addr[1:0], bus_wdata = {4{data[7:0]}}.
  - SH: bus_be = addr[1] ? 1100 : 0011, bus_wdata = {2{data[15:0]}}.
  - SW: bus_be = 1111.
  - Result: wb_data=0, reg_write_out=0.
  - bus_be=0 for reads.
- Timeout:
  - A counter increments each BUSY cycle and is cleared on entering BUSY.
  - timeout_hit is asserted when count==TIMEOUT-1 and bus_ready=0.
  - On timeout_hit: stall=0; next cycle bus_req=0, state=IDLE, valid_out=1, fault=1, cause=10, reg_write_out=0.
  - bus_ready in the final counted cycle wins over timeout.
- valid_out, fault and fault_cause are single-cycle pulses. wb_data, rd_out and reg_write_out hold their value until the next result.
- A bubble (valid_in=0) produces valid_out=0 and leaves the other outputs unchanged.

Test Plan:
- ALU op, alu_data=0x1234, rd=5, reg_write=1 -> next cycle valid_out=1, wb_data=0x1234, rd_out=5, stall never high.
- LB at addr 0x103, bus_ready in the 3rd BUSY cycle, rdata=0x80FF_0000 -> bus_addr=0x100, bus_be=0, stall high for 3 cycles, wb_data=0xFFFF_FF80.
- SH at addr 0x202, data=0xDEAD_BEEF, immediate ready -> bus_we=1, bus_be=1100, bus_wdata=0xBEEF_BEEF, reg_write_out=0, total latency 2.
- LW at addr 0x101 -> no bus_req, valid_out=1, fault=1, fault_cause=01, reg_write_out=0.
- LW with bus_ready never asserted, TIMEOUT=16 -> bus_req high for exactly 16 cycles, then fault_cause=10, stall released.
- Assert reset_n=0 during BUSY -> bus_req, stall and valid_out drop to 0 asynchronously; after release the next ALU op completes normally.
